spiker_seq_ctrl: RTL and testbench

Sequencer for the spiker core. On a software start it copies the packed input spike words from the register file into the core, issues a programmable number of timestep pulses with a per-step timeout, and copies the packed result words back into the register file. It then raises a done status and a one-cycle interrupt. It sits between the register file and the spiker core, replacing the static register-to-core wiring.

---
 rtl/spiker_seq_ctrl_pkg.sv | 19 +
 rtl/spiker_timeout_cnt.sv | 37 +++
 rtl/spiker_seq_ctrl.sv | 162 ++++++++++++++++
 tb/tb_spiker_seq_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spiker_seq_ctrl_pkg.sv
// Shared types and helpers for the spiker core sequencer.
package spiker_seq_ctrl_pkg;

    localparam int TIMEOUT_CYCLES_DEF = 4096;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STEP,
        S_WAIT,
        S_CAPTURE,
        S_DONE
    } seq_state_e;

    function automatic int n_words(input int n_spikes, input int width);
        return (n_spikes + width - 1) / width;
    endfunction

endpackage

// File: rtl/spiker_timeout_cnt.sv
// Per-timestep watchdog: counts WAIT cycles without an ack.
module spiker_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 4096,
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // High during the TIMEOUT_CYCLES-th counted cycle itself.
    assign expired_o = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !expired_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spiker_seq_ctrl.sv
// Run sequencer: load spike words, pulse timesteps, capture results.
module spiker_seq_ctrl
    import spiker_seq_ctrl_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int N_SPIKES       = 784,
    parameter int STEP_W         = 16,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    localparam int N_WORDS = n_words(N_SPIKES, WIDTH),
    localparam int IDX_W   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [STEP_W-1:0] n_steps_i,
    output logic [IDX_W-1:0]  src_addr_o,
    input  logic [WIDTH-1:0]  src_data_i,
    output logic              core_wr_o,
    output logic [IDX_W-1:0]  core_addr_o,
    output logic [WIDTH-1:0]  core_data_o,
    output logic              core_step_o,
    input  logic              core_ack_i,
    output logic [IDX_W-1:0]  core_res_addr_o,
    input  logic [WIDTH-1:0]  core_res_data_i,
    output logic              res_wr_o,
    output logic [IDX_W-1:0]  res_addr_o,
    output logic [WIDTH-1:0]  res_data_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_timeout_o,
    output logic              irq_o,
    output logic [STEP_W-1:0] step_cnt_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

    seq_state_e        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [STEP_W-1:0] nsteps_q, nsteps_d;
    logic [STEP_W-1:0] stepcnt_q, stepcnt_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              tmo_clr, tmo_en, tmo_exp;
    logic [STEP_W-1:0] step_inc;

    assign step_inc = stepcnt_q + 1'b1;

    spiker_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_tmo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (tmo_clr),
        .en_i     (tmo_en),
        .expired_o(tmo_exp)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        nsteps_d  = nsteps_q;
        stepcnt_d = stepcnt_q;
        done_d    = done_q;
        err_d     = err_q;
        tmo_clr   = 1'b0;
        tmo_en    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_i && (n_steps_i != '0)) begin
                    nsteps_d  = n_steps_i;
                    stepcnt_d = '0;
                    done_d    = 1'b0;
                    err_d     = 1'b0;
                    idx_d     = '0;
                    state_d   = S_LOAD;
                end
            end
            S_LOAD: begin
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = S_STEP;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_STEP: begin
                tmo_clr = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                tmo_en = 1'b1;
                // An ack on the final allowed cycle still counts.
                if (core_ack_i) begin
                    stepcnt_d = step_inc;
                    if (step_inc == nsteps_q) begin
                        idx_d   = '0;
                        state_d = S_CAPTURE;
                    end else begin
                        state_d = S_STEP;
                    end
                end else if (tmo_exp) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_CAPTURE: begin
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (abort_i && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            idx_d   = '0;
            done_d  = done_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            nsteps_q  <= '0;
            stepcnt_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            nsteps_q  <= nsteps_d;
            stepcnt_q <= stepcnt_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Index and data buses are forced to zero outside their strobe.
    assign core_wr_o       = (state_q == S_LOAD);
    assign core_addr_o     = core_wr_o ? idx_q : '0;
    assign src_addr_o      = core_addr_o;
    assign core_data_o     = core_wr_o ? src_data_i : '0;
    assign core_step_o     = (state_q == S_STEP);
    assign res_wr_o        = (state_q == S_CAPTURE);
    assign res_addr_o      = res_wr_o ? idx_q : '0;
    assign core_res_addr_o = res_addr_o;
    assign res_data_o      = res_wr_o ? core_res_data_i : '0;
    assign irq_o           = (state_q == S_DONE);
    assign busy_o          = (state_q != S_IDLE);
    assign done_o          = done_q;
    assign err_timeout_o   = err_q;
    assign step_cnt_o      = stepcnt_q;

endmodule

// File: tb/tb_spiker_seq_ctrl.sv
// Directed bench for spiker_seq_ctrl with a scoreboard of expected words.
module tb_spiker_seq_ctrl;

    localparam int NW  = 25;
    localparam int IW  = 5;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          start_i = 1'b0;
    logic          abort_i = 1'b0;
    logic [15:0]   n_steps_i = '0;
    logic [IW-1:0] src_addr_o;
    logic [31:0]   src_data_i;
    logic          core_wr_o;
    logic [IW-1:0] core_addr_o;
    logic [31:0]   core_data_o;
    logic          core_step_o;
    logic          core_ack_i = 1'b0;
    logic [IW-1:0] core_res_addr_o;
    logic [31:0]   core_res_data_i;
    logic          res_wr_o;
    logic [IW-1:0] res_addr_o;
    logic [31:0]   res_data_o;
    logic          busy_o, done_o, err_timeout_o, irq_o;
    logic [15:0]   step_cnt_o;

    logic [7:0] salt = 8'h10;
    int ncmp = 0;
    int nfail = 0;
    int irq_cnt = 0;
    int step_seen = 0;
    int ack_dly = 0;
    bit ack_in_step = 0;
    int dly = 0;
    int qw[$];
    int qr[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] src_fn(input logic [7:0] s, input logic [IW-1:0] a);
        return {8'h5A, s, 11'h000, a};
    endfunction

    function automatic logic [31:0] res_fn(input logic [7:0] s, input logic [IW-1:0] a);
        return {8'hC3, ~s, 11'h5A5, a};
    endfunction

    assign src_data_i      = src_fn(salt, src_addr_o);
    assign core_res_data_i = res_fn(salt, core_res_addr_o);

    spiker_seq_ctrl #(
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .start_i        (start_i),
        .abort_i        (abort_i),
        .n_steps_i      (n_steps_i),
        .src_addr_o     (src_addr_o),
        .src_data_i     (src_data_i),
        .core_wr_o      (core_wr_o),
        .core_addr_o    (core_addr_o),
        .core_data_o    (core_data_o),
        .core_step_o    (core_step_o),
        .core_ack_i     (core_ack_i),
        .core_res_addr_o(core_res_addr_o),
        .core_res_data_i(core_res_data_i),
        .res_wr_o       (res_wr_o),
        .res_addr_o     (res_addr_o),
        .res_data_o     (res_data_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .err_timeout_o  (err_timeout_o),
        .irq_o          (irq_o),
        .step_cnt_o     (step_cnt_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample at negedge, score strobes, then play the core.
    task automatic cyc();
        int a;
        @(negedge clk);
        chk("strobe_excl", 32'(int'(core_wr_o) + int'(core_step_o) + int'(res_wr_o) > 1), 0);
        if (core_wr_o) begin
            if (qw.size() == 0) begin
                chk("unexpected_core_wr", 1, 0);
            end else begin
                a = qw.pop_front();
                chk("core_addr", 32'(core_addr_o), a);
                chk("src_addr", 32'(src_addr_o), a);
                chk("core_data", core_data_o, src_fn(salt, IW'(a)));
            end
        end else begin
            chk("load_idx_zero", 32'({core_addr_o, src_addr_o}), 0);
        end
        if (res_wr_o) begin
            if (qr.size() == 0) begin
                chk("unexpected_res_wr", 1, 0);
            end else begin
                a = qr.pop_front();
                chk("res_addr", 32'(res_addr_o), a);
                chk("core_res_addr", 32'(core_res_addr_o), a);
                chk("res_data", res_data_o, res_fn(salt, IW'(a)));
            end
        end else begin
            chk("res_idx_zero", 32'({res_addr_o, core_res_addr_o}), 0);
        end
        if (core_step_o) step_seen++;
        if (irq_o) irq_cnt++;
        if (core_step_o) begin
            dly = ack_dly;
            core_ack_i = ack_in_step;
        end else if (dly > 0) begin
            dly--;
            core_ack_i = (dly == 0);
        end else begin
            core_ack_i = 1'b0;
        end
    endtask

    task automatic fill(input bit with_res);
        qw.delete();
        qr.delete();
        for (int i = 0; i < NW; i++) qw.push_back(i);
        if (with_res) for (int i = 0; i < NW; i++) qr.push_back(i);
    endtask

    task automatic run(input string tag, input int n, input int d, input bit instep,
                       input bit exp_err, input int poke_at);
        int k;
        int exp_inc;
        salt = salt + 8'h11;
        ack_dly = d;
        ack_in_step = instep;
        fill(!exp_err);
        irq_cnt = 0;
        step_seen = 0;
        exp_inc = exp_err ? (1 + NW + 1 + TMO + 1) : (1 + NW + n * (1 + d) + NW + 1);
        n_steps_i = 16'(n);
        start_i = 1'b1;
        k = 0;
        do begin
            cyc();
            k++;
            start_i = 1'b0;
            if (poke_at != 0 && k == poke_at) begin
                start_i = 1'b1;
                n_steps_i = 16'd5;
            end else begin
                n_steps_i = 16'(n);
            end
        end while (irq_cnt == 0 && k < 2000);
        start_i = 1'b0;
        chk({tag, "_irq_seen"}, 32'(irq_cnt), 1);
        chk({tag, "_irq_latency"}, k + 1, exp_inc);
        cyc();
        chk({tag, "_busy_after_irq"}, 32'(busy_o), 0);
        cyc();
        cyc();
        chk({tag, "_irq_once"}, 32'(irq_cnt), 1);
        chk({tag, "_done"}, 32'(done_o), 1);
        chk({tag, "_err"}, 32'(err_timeout_o), 32'(exp_err));
        chk({tag, "_step_cnt"}, 32'(step_cnt_o), exp_err ? 0 : n);
        chk({tag, "_step_pulses"}, step_seen, exp_err ? 1 : n);
        chk({tag, "_core_wr_left"}, qw.size(), 0);
        chk({tag, "_res_wr_left"}, qr.size(), 0);
    endtask

    initial begin
        int k;
        repeat (3) cyc();
        rst_i = 1'b0;
        cyc();
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_flags", 32'({done_o, err_timeout_o, irq_o}), 0);
        chk("rst_step_cnt", 32'(step_cnt_o), 0);
        chk("rst_strobes", 32'({core_wr_o, core_step_o, res_wr_o}), 0);

        run("normal", 3, 2, 1'b0, 1'b0, 0);

        n_steps_i = '0;
        start_i = 1'b1;
        cyc();
        start_i = 1'b0;
        chk("zero_busy", 32'(busy_o), 0);
        repeat (4) cyc();
        chk("zero_busy_later", 32'(busy_o), 0);
        chk("zero_done_kept", 32'(done_o), 1);
        chk("zero_step_cnt_kept", 32'(step_cnt_o), 3);

        run("timeout", 2, 0, 1'b0, 1'b1, 0);
        run("boundary", 2, TMO, 1'b1, 1'b0, 0);

        salt = salt + 8'h11;
        fill(1'b1);
        ack_dly = 1;
        ack_in_step = 1'b0;
        irq_cnt = 0;
        n_steps_i = 16'd1;
        start_i = 1'b1;
        cyc();
        start_i = 1'b0;
        repeat (10) cyc();
        chk("abort_word", 32'(core_addr_o), 10);
        abort_i = 1'b1;
        cyc();
        abort_i = 1'b0;
        chk("abort_busy", 32'(busy_o), 0);
        chk("abort_core_wr", 32'(core_wr_o), 0);
        repeat (5) cyc();
        chk("abort_irq", 32'(irq_cnt), 0);
        chk("abort_done", 32'(done_o), 0);
        run("restart", 1, 1, 1'b0, 1'b0, 0);

        salt = salt + 8'h11;
        fill(1'b1);
        ack_dly = 1;
        n_steps_i = 16'd1;
        start_i = 1'b1;
        cyc();
        start_i = 1'b0;
        k = 0;
        while (!(res_wr_o && res_addr_o == 5'd5) && k < 200) begin
            cyc();
            k++;
        end
        chk("rstcap_reached", 32'(res_wr_o && res_addr_o == 5'd5), 1);
        irq_cnt = 0;
        rst_i = 1'b1;
        cyc();
        rst_i = 1'b0;
        qw.delete();
        qr.delete();
        chk("rstcap_busy", 32'(busy_o), 0);
        chk("rstcap_flags", 32'({done_o, err_timeout_o, irq_o}), 0);
        chk("rstcap_step_cnt", 32'(step_cnt_o), 0);
        chk("rstcap_strobes", 32'({core_wr_o, core_step_o, res_wr_o}), 0);
        chk("rstcap_data", res_data_o | core_data_o, 0);
        repeat (3) cyc();
        chk("rstcap_no_irq", 32'(irq_cnt), 0);

        run("busystart", 2, 2, 1'b0, 1'b0, 30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
